// File: rtl/noise_stream_source.sv
// noise_stream_source
//   Two-pass reader of a stored noise record held in an external synchronous
//   sample RAM (read data valid the cycle after mem_rd_en).
//   Pass 1 (MEAN/DIVIDE): sums the record and divides by MEMORY_DEPTH to form
//   noise_mean. Pass 2 (STREAM): replays every sample on a valid/ready stream
//   with noise_mean held constant, then pulses done_stream.
//   Optional build macro NOISE_MEAN_ROUND_EN: the mean rounds half away from
//   zero instead of truncating toward zero. Timing is identical either way.
//
// Stream handshake: a sample moves from this block to the sink on every
//   rising clock edge where valid_noise && sink_ready. Once valid_noise is
//   high it stays high, and noise_signal stays unchanged, until that transfer.
//
// fsm_state exposes the FSM encoding for checkers:
//   0 IDLE, 1 MEAN, 2 DIVIDE, 3 STREAM, 4 DONE.
module noise_stream_source #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 5968,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rdata,
  input  logic                         sink_ready,
  output logic                         valid_noise,
  output logic signed [DATA_WIDTH-1:0] noise_signal,
  output logic signed [DATA_WIDTH-1:0] noise_mean,
  output logic                         mean_valid,
  output logic                         busy,
  output logic                         done_stream,
  output logic [2:0]                   fsm_state
);

  // Sum of MEMORY_DEPTH samples of DATA_WIDTH bits fits in this width
  // because MEMORY_DEPTH <= 2**ADDR_WIDTH.
  localparam int ACC_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic signed [ACC_W-1:0] DEPTH_S = ACC_W'(MEMORY_DEPTH);
`ifdef NOISE_MEAN_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF_S = ACC_W'(MEMORY_DEPTH / 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEAN   = 3'd1,
    S_DIVIDE = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Read issue bookkeeping
  logic [ADDR_WIDTH-1:0] next_addr;   // address of the next read to issue
  logic                  reads_done;  // every address of this pass issued
  logic                  ret_valid;   // mem_rdata carries a read return
  logic                  ret_last;    // that return is for LAST_ADDR

  // Mean datapath
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      dividend;
  logic signed [DATA_WIDTH-1:0] mean_q;

  // Output skid buffer: buf0 is the oldest stored sample
  logic signed [DATA_WIDTH-1:0] buf0;
  logic signed [DATA_WIDTH-1:0] buf1;
  logic [1:0]                   fifo_cnt;
  logic [1:0]                   cnt_next;
  logic [ADDR_WIDTH-1:0]        xfer_cnt;

  // Control decode
  logic restart;     // begin a pass at address 0
  logic issue;       // issue a read in the next cycle
  logic stream_ret;  // a STREAM read return is on mem_rdata this cycle
  logic pop;         // sample transfers at the coming edge
  logic stored_pop;  // the transferred sample came from the buffer
  logic push;        // read return must be stored in the buffer
  logic stream_room; // a read issued now is certain to have a slot on return

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Stream output view: buffer head first, otherwise bypass the RAM return
  always_comb begin
    stream_ret   = (state == S_STREAM) && ret_valid;
    valid_noise  = (fifo_cnt != 2'd0) || stream_ret;
    noise_signal = '0;
    if (fifo_cnt != 2'd0) noise_signal = buf0;
    else if (stream_ret)  noise_signal = mem_rdata;
    pop         = valid_noise && sink_ready;
    stored_pop  = pop && (fifo_cnt != 2'd0);
    push        = stream_ret && !((fifo_cnt == 2'd0) && pop);
    cnt_next    = fifo_cnt + 2'(push) - 2'(stored_pop);
    // The read issued now returns two edges later; the one already in flight
    // may land first, so both must fit in the two slots with no pops.
    stream_room = (cnt_next == 2'd0) || ((cnt_next == 2'd1) && !mem_rd_en);
  end

  // FSM next-state and control decode
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_MEAN;
          restart    = 1'b1;
          issue      = 1'b1;
        end
      end
      S_MEAN: begin
        issue = !reads_done;
        if (ret_valid && ret_last) state_next = S_DIVIDE;
      end
      S_DIVIDE: begin
        state_next = S_STREAM;
        restart    = 1'b1;
        issue      = 1'b1;
      end
      S_STREAM: begin
        issue = !reads_done && stream_room;
        if (pop && (xfer_cnt == LAST_ADDR)) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy        = (state != S_IDLE);
    done_stream = (state == S_DONE);
    fsm_state   = state;
  end

  // Mean divide, truncating toward zero (optionally rounded half away)
  always_comb begin
`ifdef NOISE_MEAN_ROUND_EN
    dividend = acc[ACC_W-1] ? (acc - HALF_S) : (acc + HALF_S);
`else
    dividend = acc;
`endif
    mean_q = DATA_WIDTH'(dividend / DEPTH_S);
  end

  // RAM read address generator, one read per issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      next_addr  <= '0;
      reads_done <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        if (restart) begin
          mem_addr   <= '0;
          next_addr  <= ADDR_WIDTH'(1);
          reads_done <= 1'b0;
        end else begin
          mem_addr   <= next_addr;
          next_addr  <= next_addr + ADDR_WIDTH'(1);
          reads_done <= (next_addr == LAST_ADDR);
        end
      end
    end
  end

  // Track which cycles carry read data on mem_rdata
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
    end else begin
      ret_valid <= mem_rd_en;
      ret_last  <= mem_rd_en && (mem_addr == LAST_ADDR);
    end
  end

  // Accumulate sign-extended samples during the first pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (state == S_IDLE) begin
      acc <= '0;
    end else if ((state == S_MEAN) && ret_valid) begin
      acc <= acc + $signed({{ADDR_WIDTH{mem_rdata[DATA_WIDTH-1]}}, mem_rdata});
    end
  end

  // Register the mean in DIVIDE; the old mean survives IDLE and MEAN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      noise_mean <= '0;
      mean_valid <= 1'b0;
    end else if (state == S_IDLE) begin
      mean_valid <= 1'b0;
    end else if (state == S_DIVIDE) begin
      noise_mean <= mean_q;
      mean_valid <= 1'b1;
    end
  end

  // Two-entry skid buffer holding returns the sink has not yet taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf0     <= '0;
      buf1     <= '0;
      fifo_cnt <= 2'd0;
    end else if (state == S_IDLE) begin
      fifo_cnt <= 2'd0;
    end else begin
      fifo_cnt <= cnt_next;
      case (fifo_cnt)
        2'd0: begin
          if (push) buf0 <= mem_rdata;
        end
        2'd1: begin
          if (stored_pop && push) buf0 <= mem_rdata;
          else if (push)          buf1 <= mem_rdata;
        end
        default: begin
          if (stored_pop) begin
            buf0 <= buf1;
            if (push) buf1 <= mem_rdata;
          end
        end
      endcase
    end
  end

  // Count transferred samples to find the end of the stream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt <= '0;
    end else if (state == S_DIVIDE) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_noise_stream_source.sv
// tb_noise_stream_source
//   Directed bench for noise_stream_source. A small instance (depth 8) covers
//   timing, handshake stalls, ignored start and mid-run reset; a full-size
//   instance (depth 5968) covers the extreme-value means.
//   Honors NOISE_MEAN_ROUND_EN when defined for the expected means.
module tb_noise_stream_source;

`ifdef NOISE_MEAN_ROUND_EN
  localparam logic signed [15:0] RAMP_MEAN = 16'sd5;
  localparam logic signed [15:0] NEG_MEAN  = -16'sd3;
`else
  localparam logic signed [15:0] RAMP_MEAN = 16'sd4;
  localparam logic signed [15:0] NEG_MEAN  = -16'sd2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic               s_start = 1'b0;
  logic               s_rd_en;
  logic [2:0]         s_addr;
  logic signed [15:0] s_rdata = '0;
  logic               s_ready = 1'b1;
  logic               s_valid;
  logic signed [15:0] s_signal;
  logic signed [15:0] s_mean;
  logic               s_mean_valid;
  logic               s_busy;
  logic               s_done;
  logic [2:0]         s_state;

  noise_stream_source #(.DATA_WIDTH(16), .MEMORY_DEPTH(8), .ADDR_WIDTH(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(s_start),
    .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
    .sink_ready(s_ready), .valid_noise(s_valid), .noise_signal(s_signal),
    .noise_mean(s_mean), .mean_valid(s_mean_valid), .busy(s_busy),
    .done_stream(s_done), .fsm_state(s_state)
  );

  logic signed [15:0] ram8 [0:7];
  always @(posedge clk) if (s_rd_en) s_rdata <= ram8[s_addr];

  // ---------------- full-size instance ----------------
  logic               b_start = 1'b0;
  logic               b_rd_en;
  logic [12:0]        b_addr;
  logic signed [15:0] b_rdata = '0;
  logic               b_ready = 1'b1;
  logic               b_valid;
  logic signed [15:0] b_signal;
  logic signed [15:0] b_mean;
  logic               b_mean_valid;
  logic               b_busy;
  logic               b_done;
  logic [2:0]         b_state;
  logic signed [15:0] big_fill = '0;

  noise_stream_source #(.DATA_WIDTH(16), .MEMORY_DEPTH(5968), .ADDR_WIDTH(13)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .sink_ready(b_ready), .valid_noise(b_valid), .noise_signal(b_signal),
    .noise_mean(b_mean), .mean_valid(b_mean_valid), .busy(b_busy),
    .done_stream(b_done), .fsm_state(b_state)
  );

  always @(posedge clk) if (b_rd_en) b_rdata <= big_fill;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic signed [15:0] exp_q[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ram_ramp();
    for (int i = 0; i < 8; i++) ram8[i] = 16'(i + 1);
  endtask

  task automatic set_ram_neg();
    for (int i = 0; i < 8; i++) ram8[i] = (i == 3) ? 16'sd0 : -16'sd3;
  endtask

  // mode 0: ready high; mode 1: ready toggles; mode 2: ready high plus a
  // second start pulse during STREAM. k counts cycles after the start edge.
  task automatic run8(input int mode, input logic signed [15:0] old_mean,
                      input logic signed [15:0] exp_mean);
    int k, first_v, last_v, v_cnt, done_cnt, done_k, xfers;
    logic prev_stall;
    logic signed [15:0] prev_sig;
    logic mean_moved;
    k = 0; first_v = -1; last_v = -1; v_cnt = 0; done_cnt = 0; done_k = -1;
    xfers = 0; prev_stall = 1'b0; prev_sig = '0; mean_moved = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ram8[i]);
    @(negedge clk);
    s_start = 1'b1;
    s_ready = 1'b1;
    @(posedge clk);
    while (k < 60 && (done_k < 0 || k < done_k + 2)) begin
      @(negedge clk);
      k++;
      s_start = (mode == 2) && (k == 14);
      s_ready = (mode == 1) ? (k % 2 == 0) : 1'b1;
      if (k == 1) begin
        check("busy_t1", s_busy, 1);
        check("rd_en_t1", s_rd_en, 1);
        check("addr_t1", s_addr, 0);
        check("mean_valid_in_mean", s_mean_valid, 0);
        check("old_mean_in_mean", s_mean, old_mean);
      end
      if (k == 10) begin
        check("state_divide", s_state, 2);
        check("old_mean_in_divide", s_mean, old_mean);
      end
      if (k == 11) begin
        check("mean_after_divide", s_mean, exp_mean);
        check("mean_valid_set", s_mean_valid, 1);
        check("stream_rd_en", s_rd_en, 1);
        check("stream_addr0", s_addr, 0);
      end
      if (k >= 11 && s_busy && s_mean !== exp_mean) mean_moved = 1'b1;
      if (prev_stall) begin
        check("stall_valid_hold", s_valid, 1);
        check("stall_data_hold", s_signal, prev_sig);
      end
      if (s_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        v_cnt++;
      end
      if (s_valid && s_ready) begin
        xfers++;
        if (exp_q.size() == 0) check("extra_sample", s_signal, 32'sh7fffffff);
        else                   check("sample", s_signal, exp_q.pop_front());
      end
      prev_stall = s_valid && !s_ready;
      prev_sig   = s_signal;
      if (s_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        check("done_after_last_xfer", xfers, 8);
      end
    end
    s_start = 1'b0;
    s_ready = 1'b1;
    check("done_pulses", done_cnt, 1);
    check("samples_left", exp_q.size(), 0);
    check("mean_steady", mean_moved, 0);
    check("final_mean", s_mean, exp_mean);
    check("idle_after_done", s_busy, 0);
    if (mode != 1) begin
      check("first_valid_cycle", first_v, 12);
      check("last_valid_cycle", last_v, 19);
      check("valid_cycles", v_cnt, 8);
      check("done_cycle", done_k, 20);
    end
  endtask

  task automatic run_big(input logic signed [15:0] fill,
                         input logic signed [15:0] exp_mean);
    int k, first_v, v_cnt, bad, done_k;
    k = 0; first_v = -1; v_cnt = 0; bad = 0; done_k = -1;
    big_fill = fill;
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk);
    while (k < 13000 && done_k < 0) begin
      @(negedge clk);
      k++;
      b_start = 1'b0;
      if (b_valid) begin
        if (first_v < 0) first_v = k;
        v_cnt++;
        if (b_signal !== fill) bad++;
      end
      if (b_done) done_k = k;
    end
    check("big_valid_cycles", v_cnt, 5968);
    check("big_bad_samples", bad, 0);
    check("big_first_valid", first_v, 5972);
    check("big_done_cycle", done_k, 11940);
    check("big_mean", b_mean, exp_mean);
    check("big_mean_valid", b_mean_valid, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_ram_ramp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", s_rd_en, 0);
    check("rst_addr", s_addr, 0);
    check("rst_valid", s_valid, 0);
    check("rst_signal", s_signal, 0);
    check("rst_mean", s_mean, 0);
    check("rst_mean_valid", s_mean_valid, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_state", s_state, 0);
    check("rst_big_busy", b_busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // ramp record, full throughput
    run8(0, 16'sd0, RAMP_MEAN);
    // back-to-back run with rewritten RAM
    set_ram_neg();
    run8(0, RAMP_MEAN, NEG_MEAN);
    // toggling ready
    set_ram_ramp();
    repeat (2) @(negedge clk);
    run8(1, NEG_MEAN, RAMP_MEAN);
    // start pulsed during STREAM is ignored
    repeat (2) @(negedge clk);
    run8(2, RAMP_MEAN, RAMP_MEAN);

    // reset during MEAN aborts immediately
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_state_mean", s_state, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd_en", s_rd_en, 0);
    check("mid_rst_addr", s_addr, 0);
    check("mid_rst_valid", s_valid, 0);
    check("mid_rst_mean", s_mean, 0);
    check("mid_rst_mean_valid", s_mean_valid, 0);
    check("mid_rst_busy", s_busy, 0);
    check("mid_rst_done", s_done, 0);
    @(negedge clk);
    check("mid_rst_state_next", s_state, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run8(0, 16'sd0, RAMP_MEAN);

    // extreme values at full size
    run_big(16'sh7fff, 16'sh7fff);
    repeat (2) @(negedge clk);
    run_big(-16'sh8000, -16'sh8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
